// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 64;

   // A one-bit operation still needs a one-bit counter.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, purely combinational (zero latency).
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder, one bit per clock LSB first; done pulses WIDTH cycles after start.
// start is ignored while busy (no queuing); optional subtract via SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH:0]   res_shift;

   full_adder u_fa (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
   assign res_shift = {fa_s, res_q} >> 1;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               res_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
               b_d     = sub ? ~b : b;
               c_d     = sub ? 1'b1 : cin;
`else
               b_d     = b;
               c_d     = cin;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = fa_co;
            res_d = res_shift[WIDTH-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = res_shift[WIDTH-1:0];
               cout_d  = fa_co;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           done_cyc = 0;
   int           t_first = 0;
   int           done_seen = 0;
   logic [W-1:0] last_sum = '0;
   logic         last_cout = 1'b0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs the WIDTH cycles after E0; inj>0 pulses a competing start in that RUN cycle.
   task automatic wait_done(input logic [W-1:0] es, input logic ec, input string tag, input int inj);
      for (int i = 1; i <= W; i++) begin
         @(posedge clk); #1;
         if (i == inj + 1) start = 1'b0;
         if (i < W) begin
            check({tag, "_run"}, {busy, done, cout, sum}, {1'b1, 1'b0, last_cout, last_sum});
         end else begin
            check({tag, "_done"}, {busy, done}, 2'b01);
            check({tag, "_sum"}, sum, es);
            check({tag, "_cout"}, cout, ec);
            last_sum  = es;
            last_cout = ec;
            done_cyc  = cyc;
         end
         if (i == inj) begin
            start = 1'b1;
            a     = 8'h11;
            b     = 8'h22;
            cin   = 1'b1;
         end
      end
   endtask

   // Caller is #1 after a posedge with the DUT in IDLE or DONE.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tc,
                        input logic [W-1:0] es, input logic ec, input string tag, input int inj);
      a     = ta;
      b     = tb_b;
      cin   = tc;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_e0"}, busy, 1'b1);
      wait_done(es, ec, tag, inj);
   endtask

   task automatic idle_chk(input string tag);
      @(posedge clk); #1;
      check(tag, {busy, done, cout, sum}, {1'b0, 1'b0, last_cout, last_sum});
   endtask

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      sub   = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_state", {busy, done, cout, sum}, 11'd0);
      #19 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_after_reset", {busy, done}, 2'b00);

      do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c", 0);
      idle_chk("idle_after_5a");

      do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01", 0);
      idle_chk("idle_after_ff01");
      do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c", 0);
      idle_chk("idle_after_ffff");

      // Competing start in RUN cycle 3 must be dropped.
      do_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "ign_start", 3);
      for (int k = 0; k < 4; k++) idle_chk("ign_single_done");

      // Reset in RUN cycle 4 aborts and clears the result.
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_outputs", {busy, done, cout, sum}, 11'd0);
      last_sum  = '0;
      last_cout = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      done_seen = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      check("mid_reset_no_done", done_seen, 0);
      check("mid_reset_idle", {busy, cout, sum}, 10'd0);

      // Back-to-back: second start issued during the DONE cycle.
      do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "b2b_first", 0);
      t_first = done_cyc;
      do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "b2b_second", 0);
      check("b2b_gap", done_cyc - t_first, 9);
      idle_chk("idle_after_b2b");

`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b1;
      do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub_10_01", 0);
      idle_chk("idle_after_sub1");
      do_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, "sub_00_01", 0);
      idle_chk("idle_after_sub2");
      sub = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
